// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared attack codes, state encodings and health limits
package game_pkg;

    localparam logic [7:0] MAX_HEALTH = 8'd100;

    typedef enum logic [1:0] {
        STANDBY = 2'b00,
        LIGHT   = 2'b01,
        HEAVY   = 2'b10
    } attack_e;

    typedef enum logic [0:0] {
        ATK_READY   = 1'b0,
        ATK_BLOCKED = 1'b1
    } attack_state_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_FIGHT    = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_OVER     = 3'd4
    } state_e;

    // Values above MAX_HEALTH come from 8-bit wrap-around in the mechanics subtraction.
    function automatic logic is_defeated(input logic [7:0] health);
        return (health == 8'd0) || (health > MAX_HEALTH);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer, debounce counter and registered rising-edge pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          prev_q,  prev_d;
    logic          rise_q,  rise_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = i_btn;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        // Level flips only once DEBOUNCE_CYCLES consecutive samples disagree with it.
        if (sync2_q != level_q) begin
            if (cnt_q == LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        prev_d = level_q;
        rise_d = level_q & ~prev_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_rise = rise_q;

endmodule

// File: rtl/attack_input_ctrl.sv
// rtl/attack_input_ctrl.sv - player attack transmitter: button conditioning, cooldown FSM, match-end detection
module attack_input_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LIGHT_COOLDOWN  = 8,
    parameter int HEAVY_COOLDOWN  = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_btn_light,
    input  logic       i_btn_heavy,
    input  logic       i_btn_start,
    input  logic [7:0] i_p1_health,
    input  logic [7:0] i_cpu_health,
    output logic [1:0] o_types,
    output logic       o_start,
    output logic       o_cooldown,
    output logic       o_game_over,
    output logic       o_p1_wins,
    output logic       o_draw,
    output logic [2:0] o_state
);

    localparam int MAX_CD = (LIGHT_COOLDOWN > HEAVY_COOLDOWN) ? LIGHT_COOLDOWN : HEAVY_COOLDOWN;
    localparam int CNT_W  = $clog2(MAX_CD + 1);
    localparam logic [CNT_W-1:0] LIGHT_LOAD = CNT_W'(LIGHT_COOLDOWN - 1);
    localparam logic [CNT_W-1:0] HEAVY_LOAD = CNT_W'(HEAVY_COOLDOWN - 1);

    logic light_rise, heavy_rise, start_rise;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_light (
        .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_light), .o_rise(light_rise)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_heavy (
        .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_heavy), .o_rise(heavy_rise)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_start), .o_rise(start_rise)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_cnt_q, start_cnt_d;
    logic [1:0]       types_q, types_d;
    logic             start_q, start_d;
    logic             cooldown_q, cooldown_d;
    logic             over_q, over_d;
    logic             p1_wins_q, p1_wins_d;
    logic             draw_q, draw_d;
    logic             p1_dead, cpu_dead;

    always_comb begin
        p1_dead     = is_defeated(i_p1_health);
        cpu_dead    = is_defeated(i_cpu_health);
        state_d     = state_q;
        cnt_d       = cnt_q;
        start_cnt_d = start_cnt_q;
        p1_wins_d   = p1_wins_q;
        draw_d      = draw_q;
        types_d     = STANDBY;
        cooldown_d  = 1'b0;

        if (start_rise && state_q != ST_START) begin
            state_d     = ST_START;
            cnt_d       = '0;
            start_cnt_d = 1'b0;
            p1_wins_d   = 1'b0;
            draw_d      = 1'b0;
        end else begin
            case (state_q)
                ST_START: begin
                    if (start_cnt_q) begin
                        state_d     = ST_FIGHT;
                        start_cnt_d = 1'b0;
                    end else begin
                        start_cnt_d = 1'b1;
                    end
                end
                ST_FIGHT, ST_COOLDOWN: begin
                    // Defeat outranks both new attacks and the cooldown counter.
                    if (p1_dead || cpu_dead) begin
                        state_d   = ST_OVER;
                        p1_wins_d = cpu_dead & ~p1_dead;
                        draw_d    = cpu_dead & p1_dead;
                    end else if (state_q == ST_COOLDOWN) begin
                        cooldown_d = 1'b1;
                        if (cnt_q == '0) begin
                            state_d = ST_FIGHT;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end else if (heavy_rise) begin
                        types_d = HEAVY;
                        cnt_d   = HEAVY_LOAD;
                        state_d = ST_COOLDOWN;
                    end else if (light_rise) begin
                        types_d = LIGHT;
                        cnt_d   = LIGHT_LOAD;
                        state_d = ST_COOLDOWN;
                    end
                end
                ST_IDLE, ST_OVER: ;
                default: state_d = ST_IDLE;
            endcase
        end

        start_d = (state_d == ST_START);
        over_d  = (state_d == ST_OVER);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            start_cnt_q <= 1'b0;
            types_q     <= STANDBY;
            start_q     <= 1'b0;
            cooldown_q  <= 1'b0;
            over_q      <= 1'b0;
            p1_wins_q   <= 1'b0;
            draw_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_cnt_q <= start_cnt_d;
            types_q     <= types_d;
            start_q     <= start_d;
            cooldown_q  <= cooldown_d;
            over_q      <= over_d;
            p1_wins_q   <= p1_wins_d;
            draw_q      <= draw_d;
        end
    end

    assign o_types     = types_q;
    assign o_start     = start_q;
    assign o_cooldown  = cooldown_q;
    assign o_game_over = over_q;
    assign o_p1_wins   = p1_wins_q;
    assign o_draw      = draw_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_attack_input_ctrl.sv
// tb/tb_attack_input_ctrl.sv - directed self-checking bench for attack_input_ctrl
module tb_attack_input_ctrl;

    logic       clk;
    logic       i_reset;
    logic       i_btn_light, i_btn_heavy, i_btn_start;
    logic [7:0] i_p1_health, i_cpu_health;
    logic [1:0] o_types;
    logic       o_start, o_cooldown, o_game_over, o_p1_wins, o_draw;
    logic [2:0] o_state;

    attack_input_ctrl dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_btn_light (i_btn_light),
        .i_btn_heavy (i_btn_heavy),
        .i_btn_start (i_btn_start),
        .i_p1_health (i_p1_health),
        .i_cpu_health(i_cpu_health),
        .o_types     (o_types),
        .o_start     (o_start),
        .o_cooldown  (o_cooldown),
        .o_game_over (o_game_over),
        .o_p1_wins   (o_p1_wins),
        .o_draw      (o_draw),
        .o_state     (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int bad_code = 0;

    logic [31:0] sm, lm, hm, cm;
    logic [2:0]  st_hist [0:31];
    logic [2:0]  fl_hist [0:31];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    function automatic logic [9:0] outs();
        return {o_state, o_types, o_start, o_cooldown, o_game_over, o_p1_wins, o_draw};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        sm = '0; lm = '0; hm = '0; cm = '0;
        for (int s = 0; s < 32; s++) begin
            st_hist[s] = '0;
            fl_hist[s] = '0;
        end
    endtask

    // Step index s means posedge s-1 (counted from when the stimulus was applied) has occurred.
    task automatic record(input int from, input int to);
        for (int s = from; s <= to; s++) begin
            @(negedge clk);
            sm[s] = o_start;
            lm[s] = (o_types == 2'b01);
            hm[s] = (o_types == 2'b10);
            cm[s] = o_cooldown;
            st_hist[s] = o_state;
            fl_hist[s] = {o_game_over, o_p1_wins, o_draw};
            if (o_types == 2'b11) bad_code++;
        end
    endtask

    task automatic do_start(input string tag);
        clr();
        i_btn_start = 1'b1;
        record(1, 12);
        check({tag, "_start_mask"}, sm, 32'h0000_0300);
        check({tag, "_state_s9"}, 32'(st_hist[9]), 32'd1);
        check({tag, "_state_s10"}, 32'(st_hist[10]), 32'd2);
        check({tag, "_flags_clr"}, 32'(fl_hist[8]), 32'd0);
        i_btn_start = 1'b0;
        step(10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        i_reset = 1'b1;
        i_btn_light = 1'b0; i_btn_heavy = 1'b0; i_btn_start = 1'b0;
        i_p1_health = 8'd100; i_cpu_health = 8'd100;
        step(3);
        check("reset_outs", 32'(outs()), 32'd0);
        i_reset = 1'b0;
        step(1);
        check("post_reset_outs", 32'(outs()), 32'd0);

        // Attack presses in IDLE are ignored, then the match starts.
        clr();
        i_btn_light = 1'b1;
        record(1, 12);
        check("idle_light_ignored", lm | cm, 32'd0);
        i_btn_light = 1'b0;
        step(10);
        do_start("first");

        // Light, with a heavy press landing inside the cooldown window.
        clr();
        i_btn_light = 1'b1;
        record(1, 3);
        i_btn_heavy = 1'b1;
        record(4, 24);
        check("light_mask", lm, 32'h0000_0100);
        check("light_heavy_dropped", hm, 32'd0);
        check("light_cd_mask", cm, 32'h0001_FE00);
        check("light_state_s8", 32'(st_hist[8]), 32'd3);
        check("light_state_s16", 32'(st_hist[16]), 32'd2);
        i_btn_light = 1'b0; i_btn_heavy = 1'b0;
        step(10);

        clr();
        i_btn_light = 1'b1; i_btn_heavy = 1'b1;
        record(1, 30);
        check("both_heavy_mask", hm, 32'h0000_0100);
        check("both_light_mask", lm, 32'd0);
        check("heavy_cd_mask", cm, 32'h01FF_FE00);
        i_btn_light = 1'b0; i_btn_heavy = 1'b0;
        step(10);

        clr();
        for (int i = 0; i < 10; i++) begin
            i_btn_light = (i % 2 == 0);
            record(2 * i + 1, 2 * i + 2);
        end
        check("bounce_no_attack", lm, 32'd0);
        clr();
        i_btn_light = 1'b1;
        record(1, 20);
        check("bounce_stable_light", lm, 32'h0000_0100);
        i_btn_light = 1'b0;
        step(12);

        // CPU defeated mid-cooldown.
        i_cpu_health = 8'd3;
        clr();
        i_btn_light = 1'b1;
        record(1, 11);
        check("cpu3_light", lm, 32'h0000_0100);
        check("cpu3_in_cd", 32'(cm[11]), 32'd1);
        i_cpu_health = 8'd0;
        record(12, 12);
        check("cpu0_flags", 32'(fl_hist[12]), 32'b110);
        check("cpu0_cd_off", 32'(cm[12]), 32'd0);
        check("cpu0_state", 32'(st_hist[12]), 32'd4);
        i_btn_light = 1'b0;
        i_cpu_health = 8'd100;
        step(10);
        check("over_held", 32'(outs()), {22'd0, 3'd4, 2'b00, 5'b00110});
        do_start("restart_over");

        i_p1_health = 8'd254;
        step(1);
        check("p1_wrap_flags", 32'(outs()), {22'd0, 3'd4, 2'b00, 5'b00100});
        i_p1_health = 8'd100;
        do_start("restart_p1");

        i_p1_health = 8'd0; i_cpu_health = 8'd0;
        step(1);
        check("draw_flags", 32'(outs()), {22'd0, 3'd4, 2'b00, 5'b00101});
        i_p1_health = 8'd100; i_cpu_health = 8'd100;
        do_start("restart_draw");

        // Reset in the middle of a cooldown.
        clr();
        i_btn_light = 1'b1;
        record(1, 10);
        check("pre_reset_cd", 32'(cm[10]), 32'd1);
        i_reset = 1'b1;
        step(1);
        check("reset_mid_cd", 32'(outs()), 32'd0);
        i_btn_light = 1'b0;
        step(1);
        i_reset = 1'b0;
        clr();
        record(1, 12);
        check("post_reset_no_start", sm, 32'd0);
        check("post_reset_idle", 32'(st_hist[12]), 32'd0);
        check("no_code_11", 32'(bad_code), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/attack_input_ctrl.md
# attack_input_ctrl

Player-side attack transmitter feeding the game mechanics block. It conditions three raw buttons (light, heavy, start) and issues one-cycle attack-type codes and a start pulse. It enforces per-attack cooldowns and reads back both health values to detect the end of a match and its winner. It drives the mechanics block's `i_types` and `i_start_temp` inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required before a debounced level changes.
- `LIGHT_COOLDOWN`, default 8: cycles during which attacks are blocked after a LIGHT is issued.
- `HEAVY_COOLDOWN`, default 16: cycles during which attacks are blocked after a HEAVY is issued.
- `i_clk`  in  1: single clock.
- `i_reset`  in  1: synchronous, active-high reset.
- `i_btn_light`  in  1: raw, asynchronous light-attack button.
- `i_btn_heavy`  in  1: raw, asynchronous heavy-attack button.
- `i_btn_start`  in  1: raw, asynchronous start/restart button.
- `i_p1_health`  in  8: player health from the mechanics block.
- `i_cpu_health`  in  8: CPU health from the mechanics block.
- `o_types`  out  2: attack code, one of STANDBY=00, LIGHT=01, HEAVY=10. Code 11 is never driven.
- `o_start`  out  1: start pulse to the mechanics block.
- `o_cooldown`  out  1: high while in COOLDOWN.
- `o_game_over`  out  1: high while in OVER.
- `o_p1_wins`  out  1: valid while `o_game_over` is high.
- `o_draw`  out  1: valid while `o_game_over` is high.
- `o_state`  out  3: current FSM state, for debug and display.

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level flips only after `DEBOUNCE_CYCLES` consecutive synchronized samples differ from it.
  - A registered rising-edge detect follows the debouncer. Falling edges are ignored.
- FSM states: IDLE=0, START=1, FIGHT=2, COOLDOWN=3, OVER=4.
- **IDLE:** all outputs are 0. A start edge moves to START. Attack edges are ignored.
- **START:** `o_start`=1 for exactly 2 cycles, then FIGHT. This guarantees the mechanics block has reloaded 100/100 before health is checked. Attack edges are ignored.
- **FIGHT:** the defeat check runs first.
  - Player defeated only: OVER with `o_p1_wins`=0.
  - CPU defeated only: OVER with `o_p1_wins`=1.
  - Both defeated in the same cycle: OVER with `o_draw`=1 and `o_p1_wins`=0.
  - If no one is defeated, a heavy edge drives `o_types`=HEAVY for 1 cycle and loads the counter with `HEAVY_COOLDOWN`-1. Otherwise a light edge drives `o_types`=LIGHT and loads `LIGHT_COOLDOWN`-1. Either path moves to COOLDOWN.
- **COOLDOWN:** `o_types`=STANDBY and attack edges are dropped, not queued.
  - The counter decrements each cycle. At 0 the FSM returns to FIGHT.
  - The defeat check also runs here. Defeat has priority over the counter.
- **OVER:** `o_types`=STANDBY. Winner and draw flags are held. Only a start edge leaves, moving to START.
- A start edge in any state other than IDLE or START immediately moves to START. It clears the counter, `o_p1_wins` and `o_draw`.
- Defeated is defined as health==0 or health>`MAX_HEALTH` (100). The second case covers 8-bit wrap-around in the mechanics subtraction.
- Counter width is $clog2(max(LIGHT_COOLDOWN, HEAVY_COOLDOWN)+1). A cooldown parameter below 1 is illegal.

## Timing
- Reset values: state=IDLE, `o_types`=00, and `o_start`, `o_cooldown`, `o_game_over`, `o_p1_wins`, `o_draw` all 0. Synchronizers, debouncers and the counter are cleared.
- Reset asserted mid-match returns to IDLE the next cycle. No `o_start` is produced until a new start edge.
- All outputs are registered.
- Button latency: a raw rising edge first sampled at cycle 0 produces `o_types` (or the first `o_start` cycle) at cycle 2+`DEBOUNCE_CYCLES`+1. This is 7 with the defaults.
- A defeat condition present on the health inputs at cycle N gives `o_game_over`=1 at N+1. An attack edge arriving in cycle N is suppressed.
- An attack issued at cycle N gives `o_cooldown`=1 over cycles N+1 .. N+cooldown. The next attack can be issued at N+cooldown+1 at the earliest.
- Holding a button pressed yields exactly one attack.

## Structure
- Shared package `game_pkg`:
  - attack codes STANDBY/LIGHT/HEAVY (2-bit), matching the mechanics block;
  - attack-state codes;
  - FSM state encodings;
  - `MAX_HEALTH`=100.
- Sub-module `btn_debounce`: synchronizer, debounce counter and rising-edge pulse. Instantiated three times.
- FSM, cooldown counter and defeat comparators live in `attack_input_ctrl`.

## Test plan
- Reset, then start press held 10 cycles → `o_start` high for exactly 2 cycles starting cycle 7; state reaches FIGHT at cycle 9.
- In FIGHT, light press → `o_types`=01 for 1 cycle, then `o_cooldown`=1 for 8 cycles. A heavy press inside that window produces nothing.
- Light and heavy pressed in the same cycle → `o_types`=10 once; cooldown lasts 16 cycles.
- Bounce: light toggling every 2 cycles for 20 cycles, then stable high → exactly one LIGHT, 7 cycles after the stable edge.
- Defeat cases:
  - `i_cpu_health` driven 3 → 0 during COOLDOWN → `o_game_over`=1, `o_p1_wins`=1 next cycle, `o_cooldown`=0.
  - `i_p1_health`=254 → `o_p1_wins`=0.
  - Both healths 0 in the same cycle → `o_draw`=1.
- In OVER, start press → START with 2-cycle `o_start`, flags cleared. `i_reset` mid-COOLDOWN → IDLE next cycle with all outputs 0.
